// File: rtl/macro_share_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : macro_share_ctrl
// Purpose  : Wishbone front-end shared by up to N_MACRO user macros: address
//            decode, per-access timeout, enable/IO-ownership registers.
// Revision : 1.0 - initial release
// ============================================================================
module macro_share_ctrl #(
  parameter int N_MACRO = 8,
  parameter int TIMEOUT = 255
) (
  input  logic                    wb_clk_i,
  input  logic                    wb_rstn_i,
  input  logic                    wbs_stb_i,
  input  logic                    wbs_cyc_i,
  input  logic                    wbs_we_i,
  input  logic [3:0]              wbs_sel_i,
  input  logic [31:0]             wbs_adr_i,
  input  logic [31:0]             wbs_dat_i,
  output logic                    wbs_ack_o,
  output logic [31:0]             wbs_dat_o,
  output logic [N_MACRO-1:0]      m_stb_o,
  output logic [N_MACRO-1:0]      m_cyc_o,
  output logic                    m_we_o,
  output logic [3:0]              m_sel_o,
  output logic [31:0]             m_adr_o,
  output logic [31:0]             m_dat_o,
  input  logic [N_MACRO-1:0]      m_ack_i,
  input  logic [32*N_MACRO-1:0]   m_dat_i,
  input  logic [38*N_MACRO-1:0]   m_io_out_i,
  input  logic [38*N_MACRO-1:0]   m_io_oeb_i,
  input  logic [3*N_MACRO-1:0]    m_irq_i,
  output logic [N_MACRO-1:0]      active_o,
  output logic [37:0]             io_out,
  output logic [37:0]             io_oeb,
  output logic [2:0]              user_irq
);

  localparam logic [1:0] c_idle    = 2'd0;
  localparam logic [1:0] c_fwd     = 2'd1;
  localparam logic [1:0] c_done    = 2'd2;
  localparam logic [7:0] c_timeout = 8'(TIMEOUT);

  logic [1:0]         r_state;
  logic [N_MACRO-1:0] r_en;
  logic [3:0]         r_owner;
  logic [3:0]         r_win;
  logic [3:0]         r_last_win;
  logic               r_to;
  logic               r_err;
  logic [7:0]         r_cnt;
  logic [31:0]        r_dat;

  logic        w_req;
  logic [3:0]  w_win;
  logic        w_hit;
  logic        w_sel_ack;
  logic [31:0] w_sel_dat;
  logic [31:0] w_reg_rdata;

  assign w_req = wbs_cyc_i & wbs_stb_i;
  assign w_win = wbs_adr_i[23:20];

  // Address, data and byte selects go to every macro; only the strobe is decoded.
  assign m_we_o  = wbs_we_i;
  assign m_sel_o = wbs_sel_i;
  assign m_adr_o = wbs_adr_i;
  assign m_dat_o = wbs_dat_i;
  assign m_cyc_o = m_stb_o;

  assign wbs_ack_o = (r_state == c_done);
  assign wbs_dat_o = r_dat;
  assign active_o  = r_en;

  always_comb begin
    w_hit     = 1'b0;
    w_sel_ack = 1'b0;
    w_sel_dat = '0;
    m_stb_o   = '0;
    for (int k = 0; k < N_MACRO; k++) begin
      if (w_win == 4'(k + 1) && r_en[k])
        w_hit = 1'b1;
      if (r_win == 4'(k + 1)) begin
        w_sel_ack  = m_ack_i[k];
        w_sel_dat  = m_dat_i[32*k +: 32];
        m_stb_o[k] = (r_state == c_fwd) && w_req;
      end
    end
  end

  always_comb begin
    case (wbs_adr_i[3:2])
      2'd0:    w_reg_rdata = 32'(r_en);
      2'd1:    w_reg_rdata = {28'd0, r_owner};
      2'd2:    w_reg_rdata = {24'd0, r_last_win, 2'b00, r_err, r_to};
      default: w_reg_rdata = '0;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
    if (!wb_rstn_i) begin
      r_state    <= c_idle;
      r_en       <= '0;
      r_owner    <= '0;
      r_win      <= '0;
      r_last_win <= '0;
      r_to       <= 1'b0;
      r_err      <= 1'b0;
      r_cnt      <= '0;
      r_dat      <= '0;
    end else begin
      case (r_state)
        c_idle: begin
          if (w_req) begin
            if (w_win == 4'd0) begin
              r_state    <= c_done;
              r_last_win <= 4'd0;
              if (wbs_we_i) begin
                r_dat <= '0;
                case (wbs_adr_i[3:2])
                  2'd0: r_en    <= wbs_dat_i[N_MACRO-1:0];
                  2'd1: r_owner <= wbs_dat_i[3:0];
                  2'd3: begin
                    if (wbs_dat_i[0]) r_to  <= 1'b0;
                    if (wbs_dat_i[1]) r_err <= 1'b0;
                  end
                  default: ;
                endcase
              end else begin
                r_dat <= w_reg_rdata;
              end
            end else if (w_hit) begin
              r_state <= c_fwd;
              r_win   <= w_win;
              r_cnt   <= c_timeout;
            end else begin
              r_state    <= c_done;
              r_err      <= 1'b1;
              r_dat      <= '0;
              r_last_win <= w_win;
            end
          end
        end
        c_fwd: begin
          // Ack is checked before the expiry so a last-cycle ack still succeeds.
          if (!wbs_cyc_i) begin
            r_state <= c_idle;
          end else if (w_sel_ack) begin
            r_state    <= c_done;
            r_dat      <= w_sel_dat;
            r_last_win <= r_win;
          end else if (r_cnt == 8'd0) begin
            r_state    <= c_done;
            r_to       <= 1'b1;
            r_dat      <= 32'hFFFF_FFFF;
            r_last_win <= r_win;
          end else begin
            r_cnt <= r_cnt - 8'd1;
          end
        end
        default: r_state <= c_idle;
      endcase
    end
  end

  // Pads are released unless the owner index names an enabled macro.
  always_comb begin
    io_out = '0;
    io_oeb = '1;
    for (int k = 0; k < N_MACRO; k++) begin
      if (r_owner == 4'(k) && r_en[k]) begin
        io_out = m_io_out_i[38*k +: 38];
        io_oeb = m_io_oeb_i[38*k +: 38];
      end
    end
  end

  always_comb begin
    user_irq = '0;
    for (int k = 0; k < N_MACRO; k++)
      user_irq = user_irq | (m_irq_i[3*k +: 3] & {3{r_en[k]}});
  end

endmodule
`default_nettype wire

// File: tb/tb_macro_share_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_macro_share_ctrl
// Purpose  : Scoreboard bench for macro_share_ctrl (N_MACRO=8, TIMEOUT=8).
// Revision : 1.0 - initial release
// ============================================================================
module tb_macro_share_ctrl;

  localparam int N  = 8;
  localparam int TO = 8;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            stb, cyc, we;
  logic [3:0]      sel;
  logic [31:0]     adr, wdat;
  logic            ack;
  logic [31:0]     rdat;
  logic [N-1:0]    m_stb, m_cyc;
  logic            m_we;
  logic [3:0]      m_sel;
  logic [31:0]     m_adr, m_dat;
  logic [N-1:0]    m_ack;
  logic [32*N-1:0] m_rdat;
  logic [38*N-1:0] m_io_out, m_io_oeb;
  logic [3*N-1:0]  m_irq;
  logic [N-1:0]    active;
  logic [37:0]     io_out, io_oeb;
  logic [2:0]      user_irq;

  int n_total = 0;
  int n_bad   = 0;
  logic [32:0] q_exp[$];  // {check_data, data}

  always #5 clk = ~clk;

  macro_share_ctrl #(.N_MACRO(N), .TIMEOUT(TO)) dut (
    .wb_clk_i(clk), .wb_rstn_i(rst_n),
    .wbs_stb_i(stb), .wbs_cyc_i(cyc), .wbs_we_i(we), .wbs_sel_i(sel),
    .wbs_adr_i(adr), .wbs_dat_i(wdat), .wbs_ack_o(ack), .wbs_dat_o(rdat),
    .m_stb_o(m_stb), .m_cyc_o(m_cyc), .m_we_o(m_we), .m_sel_o(m_sel),
    .m_adr_o(m_adr), .m_dat_o(m_dat), .m_ack_i(m_ack), .m_dat_i(m_rdat),
    .m_io_out_i(m_io_out), .m_io_oeb_i(m_io_oeb), .m_irq_i(m_irq),
    .active_o(active), .io_out(io_out), .io_oeb(io_oeb), .user_irq(user_irq)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [37:0] io_pat(input int k);
    return {6'(k + 1), 32'hC0DE_0000 | 32'(k)};
  endfunction

  function automatic logic [37:0] oeb_pat(input int k);
    return {6'h2A, 32'h5A5A_0000 | 32'(k)};
  endfunction

  // Scoreboard: every ack pops one expectation pushed by the driver.
  always @(negedge clk) begin
    if (ack) begin
      if (q_exp.size() == 0) begin
        check("unexp_ack", 64'(ack), 64'd0);
      end else begin
        logic [32:0] e;
        e = q_exp.pop_front();
        if (e[32]) check("rdata", 64'(rdat), 64'(e[31:0]));
      end
    end
  end

  // One Wishbone access; macro ack_k (or none if <0) acks after ack_delay strobe
  // cycles (0 = silent) while the other macros in other_mask hold ack high.
  task automatic xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                      input logic do_chk, input logic [31:0] exp, input int exp_lat,
                      input int ack_k, input int ack_delay, input logic [N-1:0] other_mask);
    int n = 0, sc = 0, exp_sc;
    logic got = 1'b0, sbad = 1'b0;
    logic [N-1:0] own, exp_stb;
    own     = (ack_k >= 0) ? (N'(1) << ack_k) : '0;
    exp_stb = own;
    exp_sc  = (ack_k < 0) ? 0 : (ack_delay == 0 ? TO + 1 : ack_delay);
    q_exp.push_back({do_chk, exp});
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; wdat = d;
    m_ack = other_mask;
    while (!got && n < 300) begin
      @(negedge clk);
      n++;
      if (m_stb != '0) begin
        sc++;
        if (m_stb != exp_stb) sbad = 1'b1;
      end
      if (ack) got = 1'b1;
      else m_ack = other_mask | ((ack_delay > 0 && sc == ack_delay) ? own : '0);
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0; m_ack = '0;
    if (!got) q_exp.delete();
    check("latency", 64'(n - 1), 64'(exp_lat));
    check("stb_cycles", 64'(sc), 64'(exp_sc));
    check("stb_value", 64'(sbad), 64'd0);
  endtask

  task automatic reg_wr(input logic [3:0] r, input logic [31:0] d);
    xfer(1'b1, {28'd0, r}, d, 1'b0, 32'd0, 1, -1, 0, '0);
  endtask

  task automatic reg_rd(input logic [3:0] r, input logic [31:0] exp);
    xfer(1'b0, {28'd0, r}, 32'd0, 1'b1, exp, 1, -1, 0, '0);
  endtask

  function automatic logic [31:0] win_adr(input int w);
    return 32'(w) << 20;
  endfunction

  // Forward a read to window 3 and interrupt it in FWD cycle 2 (cyc drop or reset).
  task automatic interrupt_fwd(input logic use_reset);
    int acks = 0;
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = win_adr(3);
    repeat (3) @(negedge clk);
    check("intr_stb_before", 64'(m_stb), 64'h04);
    if (use_reset) begin
      rst_n = 1'b0;
      #1;
      check("rst_stb", 64'(m_stb), 64'd0);
      check("rst_ack", 64'(ack), 64'd0);
      check("rst_dat", 64'(rdat), 64'd0);
      check("rst_active", 64'(active), 64'd0);
      check("rst_io_out", 64'(io_out), 64'd0);
      check("rst_io_oeb", 64'(io_oeb), 64'h3F_FFFF_FFFF);
      check("rst_irq", 64'(user_irq), 64'd0);
      cyc = 1'b0; stb = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
    end else begin
      cyc = 1'b0; stb = 1'b0;
      #1;
      check("abort_stb", 64'(m_stb), 64'd0);
      for (int i = 0; i < TO + 4; i++) begin
        @(negedge clk);
        if (ack) acks++;
      end
      check("abort_noack", 64'(acks), 64'd0);
    end
  endtask

  initial begin
    rst_n = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'hF;
    adr = '0; wdat = '0; m_ack = '0; m_irq = '1;
    for (int k = 0; k < N; k++) begin
      m_rdat[32*k +: 32]  = (k == 2) ? 32'h1234_5678 : (32'hA5A5_0000 | 32'(k));
      m_io_out[38*k +: 38] = io_pat(k);
      m_io_oeb[38*k +: 38] = oeb_pat(k);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_ack", 64'(ack), 64'd0);
    check("reset_dat", 64'(rdat), 64'd0);
    check("reset_stb", 64'(m_stb), 64'd0);
    check("reset_active", 64'(active), 64'd0);
    check("reset_io_out", 64'(io_out), 64'd0);
    check("reset_io_oeb", 64'(io_oeb), 64'h3F_FFFF_FFFF);
    check("reset_irq", 64'(user_irq), 64'd0);
    rst_n = 1'b1;

    reg_wr(4'h0, 32'h05);
    reg_wr(4'h4, 32'h2);
    check("active", 64'(active), 64'h05);
    check("io_out_m2", 64'(io_out), 64'(io_pat(2)));
    check("io_oeb_m2", 64'(io_oeb), 64'(oeb_pat(2)));
    #1 check("irq_all", 64'(user_irq), 64'h7);
    m_irq = 24'h00_0038;
    #1 check("irq_disabled", 64'(user_irq), 64'h0);
    m_irq = 24'h00_0080;
    #1 check("irq_m2_b1", 64'(user_irq), 64'h2);
    reg_rd(4'h0, 32'h05);
    reg_rd(4'h4, 32'h2);

    xfer(1'b0, win_adr(3), 32'd0, 1'b1, 32'h1234_5678, 5, 2, 4, 8'hFB);
    reg_rd(4'h8, 32'h30);

    xfer(1'b0, win_adr(1), 32'd0, 1'b1, 32'hFFFF_FFFF, TO + 2, 0, 0, '0);
    reg_rd(4'h8, 32'h11);
    reg_rd(4'hC, 32'h0);
    reg_wr(4'hC, 32'h1);
    reg_rd(4'h8, 32'h00);

    xfer(1'b0, win_adr(3), 32'd0, 1'b1, 32'h1234_5678, TO + 2, 2, TO + 1, '0);
    reg_rd(4'h8, 32'h30);

    xfer(1'b0, win_adr(2), 32'd0, 1'b1, 32'd0, 1, -1, 0, '0);
    reg_rd(4'h8, 32'h22);
    xfer(1'b1, win_adr(15), 32'hDEAD_BEEF, 1'b1, 32'd0, 1, -1, 0, '0);
    reg_rd(4'h8, 32'hF2);
    xfer(1'b0, win_adr(N + 1), 32'd0, 1'b1, 32'd0, 1, -1, 0, '0);
    reg_wr(4'hC, 32'h2);
    reg_rd(4'h8, 32'h00);

    reg_wr(4'h4, 32'h9);
    check("io_oeb_badown", 64'(io_oeb), 64'h3F_FFFF_FFFF);
    check("io_out_badown", 64'(io_out), 64'd0);
    reg_wr(4'h4, 32'h1);
    check("io_oeb_disown", 64'(io_oeb), 64'h3F_FFFF_FFFF);
    reg_wr(4'h4, 32'h0);
    check("io_out_m0", 64'(io_out), 64'(io_pat(0)));

    interrupt_fwd(1'b0);
    reg_rd(4'h0, 32'h05);

    interrupt_fwd(1'b1);
    reg_rd(4'h0, 32'h00);
    reg_rd(4'h8, 32'h00);

    repeat (2) @(negedge clk);
    check("queue_empty", 64'(q_exp.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "bench time limit");
  end

endmodule
`default_nettype wire
